// File: rtl/kersram_rd_seq.sv
// Kernel-SRAM read sequencer: walks base + ker*once_cp + cp per column output
// and kernel group, issuing one read per cycle staggered one cycle per bank.
module kersram_rd_seq #(
    parameter int unsigned NUM_BANK = 8,
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned CNT_W    = 10
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic                         start_i,
    input  logic [CNT_W-1:0]             cfg_ch_addr_i,
    input  logic [3:0]                   cfg_cp_pix_i,
    input  logic [CNT_W-1:0]             cfg_ker_grp_i,
    input  logic [CNT_W-1:0]             cfg_colout_i,
    input  logic [ADDR_W-1:0]            cfg_base_i,
    input  logic                         stall_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         cfg_err_o,
    output logic [NUM_BANK-1:0]          cen_o,
    output logic [NUM_BANK-1:0]          wen_o,
    output logic [NUM_BANK*ADDR_W-1:0]   addr_o,
    output logic [NUM_BANK-1:0]          valid_o,
    output logic [NUM_BANK-1:0]          final_o
);

    localparam int unsigned PIPE_LEN = NUM_BANK + RD_LAT;
    localparam int unsigned PROD_W   = 2 * CNT_W;
    localparam int unsigned DRN_W    = $clog2(PIPE_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0]  once_cp_q, ker_grp_q, colout_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  cp_q, col_q, ker_q;
    logic [ADDR_W-1:0] ker_off_q;
    logic [DRN_W-1:0]  drain_q;

    logic [PIPE_LEN-1:0] en_q, fin_q;
    logic [ADDR_W-1:0]   adr_q [NUM_BANK];

    logic busy_q, done_q, cfg_err_q;

    logic [PROD_W-1:0] prod_c;
    logic              cfg_bad_c;
    logic              cp_last_c, col_last_c, ker_last_c, last_c;
    logic              issue_c;
    logic [ADDR_W-1:0] a0_c;

    // once_cp at double width so an oversize product is detectable
    assign prod_c    = PROD_W'(cfg_ch_addr_i) * PROD_W'(cfg_cp_pix_i);
    assign cfg_bad_c = (cfg_ch_addr_i == '0) || (cfg_cp_pix_i == '0) ||
                       (cfg_ker_grp_i == '0) || (cfg_colout_i == '0) ||
                       (|prod_c[PROD_W-1:CNT_W]);

    assign cp_last_c  = (cp_q  == once_cp_q - CNT_W'(1));
    assign col_last_c = (col_q == colout_q  - CNT_W'(1));
    assign ker_last_c = (ker_q == ker_grp_q - CNT_W'(1));
    assign last_c     = cp_last_c && col_last_c && ker_last_c;
    assign a0_c       = base_q + ker_off_q + ADDR_W'(cp_q);

    // state register
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and issue decision
    always_comb begin
        state_d = state_q;
        issue_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = cfg_bad_c ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (!stall_i) begin
                    issue_c = 1'b1;
                    if (last_c) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRN_W'(PIPE_LEN - 1)) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // layer config and walk counters
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            once_cp_q <= '0;
            ker_grp_q <= '0;
            colout_q  <= '0;
            base_q    <= '0;
            cp_q      <= '0;
            col_q     <= '0;
            ker_q     <= '0;
            ker_off_q <= '0;
            drain_q   <= '0;
        end else begin
            if (state_q == S_LOAD) begin
                once_cp_q <= prod_c[CNT_W-1:0];
                ker_grp_q <= cfg_ker_grp_i;
                colout_q  <= cfg_colout_i;
                base_q    <= cfg_base_i;
                cp_q      <= '0;
                col_q     <= '0;
                ker_q     <= '0;
                ker_off_q <= '0;
            end else if (issue_c) begin
                if (!cp_last_c) begin
                    cp_q <= cp_q + CNT_W'(1);
                end else begin
                    cp_q <= '0;
                    if (!col_last_c) begin
                        col_q <= col_q + CNT_W'(1);
                    end else begin
                        col_q     <= '0;
                        ker_q     <= ker_q + CNT_W'(1);
                        ker_off_q <= ker_off_q + ADDR_W'(once_cp_q);
                    end
                end
            end
            drain_q <= (state_q == S_DRAIN) ? drain_q + DRN_W'(1) : '0;
        end
    end

    // stagger delay line; bubbles carry address 0 so banks idle at addr 0
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            en_q  <= '0;
            fin_q <= '0;
            for (int unsigned i = 0; i < NUM_BANK; i++) adr_q[i] <= '0;
        end else begin
            en_q     <= {en_q[PIPE_LEN-2:0], issue_c};
            fin_q    <= {fin_q[PIPE_LEN-2:0], issue_c & cp_last_c};
            adr_q[0] <= issue_c ? a0_c : '0;
            for (int unsigned i = 1; i < NUM_BANK; i++) adr_q[i] <= adr_q[i-1];
        end
    end

    // status flags follow the state being entered
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
            cfg_err_q <= (state_q == S_LOAD) && cfg_bad_c;
        end
    end

    for (genvar i = 0; i < NUM_BANK; i++) begin : g_bank
        assign addr_o[i*ADDR_W +: ADDR_W] = adr_q[i];
    end

    assign cen_o     = ~en_q[NUM_BANK-1:0];
    assign wen_o     = '1;
    assign valid_o   = en_q[PIPE_LEN-1:RD_LAT];
    assign final_o   = fin_q[PIPE_LEN-1:RD_LAT];
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign cfg_err_o = cfg_err_q;

endmodule
